mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage RISC-V core; consumes the EX/MEM pipeline register outputs and drives the MEM/WB register outputs.
- Performs word loads and stores on the data memory over a valid/ready request and valid response handshake.
- Raises a stall that freezes PC, IF/ID, ID/EX and EX/MEM while a memory transaction is outstanding.
- Detects misaligned accesses and memory timeouts, and squashes the register write for them.

Parameters:
- TIMEOUT_CYCLES, 200: max cycles spent in REQ+RESP before abort.
- CNT_W, 8: timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset: asynchronous, active-high
- ma_pc_plus_4_in  in  32  PC+4 from EX/MEM
- ma_alu_result_in  in  32  ALU result / memory address
- ma_write_data_in  in  32  store data (rs2)
- ma_rd_addr_in  in  5  destination register
- ma_mem_read_in  in  1  load
- ma_mem_write_in  in  1  store
- ma_reg_write_in  in  1  register write enable
- ma_mem_to_reg_in  in  1  writeback select
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_req_we  out  1  1 = store
- dmem_req_addr  out  32  word-aligned address
- dmem_req_wdata  out  32  store data
- dmem_resp_valid  in  1  load data valid
- dmem_resp_rdata  in  32  load data
- stall_out  out  1  freeze upstream stages (combinational)
- wb_valid_out  out  1  MEM/WB slot holds a real instruction
- wb_pc_plus_4_out  out  32  registered
- wb_alu_result_out  out  32  registered
- wb_mem_data_out  out  32  registered load data
- wb_rd_addr_out  out  5  registered
- wb_reg_write_out  out  1  registered
- wb_mem_to_reg_out  out  1  registered
- misaligned_err_out  out  1  one-cycle pulse
- bus_err_out  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: state = IDLE; all outputs 0, including dmem_req_valid, stall_out and the error pulses. Timeout counter and capture registers = 0. Reset mid-transaction abandons the request, and memory must tolerate the drop.
- FSM states: IDLE, REQ, RESP, DONE.
- mem op = mem_read | mem_write. If both are set, treat as a load and ignore the write.
- IDLE, no mem op: MEM/WB loads the inputs every cycle, with wb_valid = 1 and wb_mem_data = 0. Stall = 0. One-cycle latency.
- IDLE, mem op, addr[1:0] != 0:
  - No request is issued; misaligned_err pulses.
  - MEM/WB loads the inputs with wb_reg_write = 0 and wb_valid = 1.
  - Stall = 0.
- IDLE, aligned mem op:
  - stall_out = 1; capture addr, wdata, we, rd and control bits.
  - MEM/WB loads a bubble (all control 0, wb_valid = 0).
  - Next state REQ.
- REQ:
  - dmem_req_valid = 1; addr, wdata and we come from the capture registers and are held stable until accepted. Stall = 1. Bubble into MEM/WB.
  - valid & ready with a store: next state DONE.
  - valid & ready with a load: next state RESP.
- RESP:
  - Stall = 1; dmem_req_valid = 0. Bubble into MEM/WB.
  - resp_valid: capture rdata; next state DONE.
  - resp_valid is ignored outside RESP. Memory guarantees at least one cycle between accept and response.
- DONE:
  - Stall = 0. MEM/WB loads the captured instruction with wb_valid = 1 and wb_mem_data = captured rdata (0 for a store). Next state IDLE.
  - EX/MEM advances on the same edge.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - On reaching TIMEOUT_CYCLES: drop req_valid, pulse bus_err, go to DONE with wb_reg_write = 0 and wb_mem_data = 0.
  - A late response is ignored.
- Minimum latency:
  - Store: 2 stall cycles (IDLE, REQ), commit in DONE.
  - Load: 3 stall cycles (IDLE, REQ, RESP), commit in DONE.
- dmem_req_addr carries the full 32-bit address with bits [1:0] = 00.

Decomposition:
- Shared package (core_pkg) holds the FSM state encoding (2-bit IDLE=0, REQ=1, RESP=2, DONE=3) and the XLEN=32 and REG_ADDR_W=5 constants.
- One natural sub-module, mem_wb_buffer: the MEM/WB register with load-enable and bubble-insert. Its outputs reset asynchronously to 0.
- FSM, capture registers and timeout counter stay in mem_access_stage.

Test Plan:
- ALU op (alu=0x0000_0010, rd=5, reg_write=1, no mem) -> next edge wb_alu_result=0x10, wb_rd=5, wb_reg_write=1, wb_valid=1; stall never asserted.
- Store addr=0x100, data=0xDEADBEEF, ready high -> req_valid for 1 cycle with addr 0x100, we=1, wdata 0xDEADBEEF; stall high 2 cycles; DONE writes wb_valid=1, wb_reg_write=0.
- Load addr=0x200, ready delayed 3 cycles, rdata=0xCAFEF00D 2 cycles after accept -> addr held stable through the wait; stall high 6 cycles; wb_mem_data=0xCAFEF00D, wb_mem_to_reg=1.
- Load addr=0x202 -> no req_valid; misaligned_err pulses 1 cycle; wb_reg_write=0; no stall.
- Load with ready never asserted, TIMEOUT_CYCLES=200 -> bus_err pulses after 200 cycles in REQ, wb_reg_write=0, FSM returns to IDLE.
- Assert rst while in RESP -> all outputs 0 immediately; a resp_valid arriving after reset release is ignored; the next ALU op flows normally.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: datapath widths and the MEM-stage FSM encoding.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } mem_state_e;

endpackage

// File: rtl/mem_wb_buffer.sv
// MEM/WB pipeline register: loads the next slot when enabled, or a bubble
// (everything zero, slot invalid) when bubble-insert is requested.
module mem_wb_buffer
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_en,
    input  logic                  i_bubble,
    input  logic                  i_valid,
    input  logic [XLEN-1:0]       i_pc_plus_4,
    input  logic [XLEN-1:0]       i_alu_result,
    input  logic [XLEN-1:0]       i_mem_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic                  i_reg_write,
    input  logic                  i_mem_to_reg,
    output logic                  o_valid,
    output logic [XLEN-1:0]       o_pc_plus_4,
    output logic [XLEN-1:0]       o_alu_result,
    output logic [XLEN-1:0]       o_mem_data,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic                  o_reg_write,
    output logic                  o_mem_to_reg
);

    logic                  r_valid;
    logic [XLEN-1:0]       r_pc_plus_4;
    logic [XLEN-1:0]       r_alu_result;
    logic [XLEN-1:0]       r_mem_data;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc_plus_4  <= '0;
            r_alu_result <= '0;
            r_mem_data   <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (i_en) begin
            if (i_bubble) begin
                r_valid      <= 1'b0;
                r_pc_plus_4  <= '0;
                r_alu_result <= '0;
                r_mem_data   <= '0;
                r_rd_addr    <= '0;
                r_reg_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
            end else begin
                r_valid      <= i_valid;
                r_pc_plus_4  <= i_pc_plus_4;
                r_alu_result <= i_alu_result;
                r_mem_data   <= i_mem_data;
                r_rd_addr    <= i_rd_addr;
                r_reg_write  <= i_reg_write;
                r_mem_to_reg <= i_mem_to_reg;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_pc_plus_4  = r_pc_plus_4;
    assign o_alu_result = r_alu_result;
    assign o_mem_data   = r_mem_data;
    assign o_rd_addr    = r_rd_addr;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: word loads/stores on the data memory, upstream stall while a
// transaction is outstanding, misalignment and timeout detection.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200,
    parameter int CNT_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       ma_pc_plus_4_in,
    input  logic [XLEN-1:0]       ma_alu_result_in,
    input  logic [XLEN-1:0]       ma_write_data_in,
    input  logic [REG_ADDR_W-1:0] ma_rd_addr_in,
    input  logic                  ma_mem_read_in,
    input  logic                  ma_mem_write_in,
    input  logic                  ma_reg_write_in,
    input  logic                  ma_mem_to_reg_in,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_req_we,
    output logic [XLEN-1:0]       dmem_req_addr,
    output logic [XLEN-1:0]       dmem_req_wdata,
    input  logic                  dmem_resp_valid,
    input  logic [XLEN-1:0]       dmem_resp_rdata,
    output logic                  stall_out,
    output logic                  wb_valid_out,
    output logic [XLEN-1:0]       wb_pc_plus_4_out,
    output logic [XLEN-1:0]       wb_alu_result_out,
    output logic [XLEN-1:0]       wb_mem_data_out,
    output logic [REG_ADDR_W-1:0] wb_rd_addr_out,
    output logic                  wb_reg_write_out,
    output logic                  wb_mem_to_reg_out,
    output logic                  misaligned_err_out,
    output logic                  bus_err_out,
    output logic [1:0]            dbg_state_out
);

    mem_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [XLEN-1:0]       r_pc_plus_4;
    logic [XLEN-1:0]       r_alu_result;
    logic [XLEN-1:0]       r_wdata;
    logic [XLEN-1:0]       r_rdata;
    logic [REG_ADDR_W-1:0] r_rd_addr;
    logic                  r_we;
    logic                  r_reg_write;
    logic                  r_mem_to_reg;
    logic                  r_timed_out;
    logic                  r_misaligned_err;
    logic                  r_bus_err;

    logic                  w_mem_op;
    logic                  w_misaligned;
    logic                  w_start;
    logic                  w_busy;
    logic                  w_timeout;

    logic                  w_wb_bubble;
    logic                  w_wb_valid;
    logic [XLEN-1:0]       w_wb_pc_plus_4;
    logic [XLEN-1:0]       w_wb_alu_result;
    logic [XLEN-1:0]       w_wb_mem_data;
    logic [REG_ADDR_W-1:0] w_wb_rd_addr;
    logic                  w_wb_reg_write;
    logic                  w_wb_mem_to_reg;

    assign w_mem_op     = ma_mem_read_in | ma_mem_write_in;
    assign w_misaligned = w_mem_op & (ma_alu_result_in[1:0] != 2'b00);
    assign w_start      = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
    assign w_busy       = (r_state == S_REQ) | (r_state == S_RESP);
    assign w_timeout    = w_busy & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Handshake: a request transfers on a cycle where dmem_req_valid and
    // dmem_req_ready are both high; valid is never withdrawn before that
    // except on timeout or reset, and addr/we/wdata stay constant while
    // valid is high. A load response is a single-cycle dmem_resp_valid
    // with no back-pressure, honoured only while waiting in RESP.
    assign dmem_req_valid = (r_state == S_REQ);
    assign dmem_req_we    = r_we;
    assign dmem_req_addr  = {r_alu_result[XLEN-1:2], 2'b00};
    assign dmem_req_wdata = r_wdata;

    // Gated by rst so the upstream freeze drops the moment reset asserts.
    assign stall_out          = ~rst & (w_start | w_busy);
    assign misaligned_err_out = r_misaligned_err;
    assign bus_err_out        = r_bus_err;
    assign dbg_state_out      = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_pc_plus_4      <= '0;
            r_alu_result     <= '0;
            r_wdata          <= '0;
            r_rdata          <= '0;
            r_rd_addr        <= '0;
            r_we             <= 1'b0;
            r_reg_write      <= 1'b0;
            r_mem_to_reg     <= 1'b0;
            r_timed_out      <= 1'b0;
            r_misaligned_err <= 1'b0;
            r_bus_err        <= 1'b0;
        end else begin
            r_misaligned_err <= 1'b0;
            r_bus_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_misaligned) begin
                        r_misaligned_err <= 1'b1;
                    end else if (w_start) begin
                        r_pc_plus_4  <= ma_pc_plus_4_in;
                        r_alu_result <= ma_alu_result_in;
                        r_wdata      <= ma_write_data_in;
                        r_rd_addr    <= ma_rd_addr_in;
                        r_we         <= ma_mem_write_in & ~ma_mem_read_in;
                        r_reg_write  <= ma_reg_write_in;
                        r_mem_to_reg <= ma_mem_to_reg_in;
                        r_rdata      <= '0;
                        r_timed_out  <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (dmem_req_ready) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= r_we ? S_DONE : S_RESP;
                    end else if (w_timeout) begin
                        r_bus_err   <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (dmem_resp_valid) begin
                        r_rdata <= dmem_resp_rdata;
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_bus_err   <= 1'b1;
                        r_timed_out <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Next MEM/WB slot: pass-through in IDLE, captured instruction in DONE, bubble otherwise.
    always_comb begin
        w_wb_bubble     = 1'b1;
        w_wb_valid      = 1'b0;
        w_wb_pc_plus_4  = ma_pc_plus_4_in;
        w_wb_alu_result = ma_alu_result_in;
        w_wb_mem_data   = '0;
        w_wb_rd_addr    = ma_rd_addr_in;
        w_wb_reg_write  = 1'b0;
        w_wb_mem_to_reg = ma_mem_to_reg_in;
        if ((r_state == S_IDLE) && !w_start) begin
            w_wb_bubble    = 1'b0;
            w_wb_valid     = 1'b1;
            w_wb_reg_write = ma_reg_write_in & ~w_misaligned;
        end else if (r_state == S_DONE) begin
            w_wb_bubble     = 1'b0;
            w_wb_valid      = 1'b1;
            w_wb_pc_plus_4  = r_pc_plus_4;
            w_wb_alu_result = r_alu_result;
            w_wb_mem_data   = r_rdata;
            w_wb_rd_addr    = r_rd_addr;
            w_wb_reg_write  = r_reg_write & ~r_timed_out;
            w_wb_mem_to_reg = r_mem_to_reg;
        end
    end

    mem_wb_buffer u_mem_wb (
        .clk          (clk),
        .rst          (rst),
        .i_en         (1'b1),
        .i_bubble     (w_wb_bubble),
        .i_valid      (w_wb_valid),
        .i_pc_plus_4  (w_wb_pc_plus_4),
        .i_alu_result (w_wb_alu_result),
        .i_mem_data   (w_wb_mem_data),
        .i_rd_addr    (w_wb_rd_addr),
        .i_reg_write  (w_wb_reg_write),
        .i_mem_to_reg (w_wb_mem_to_reg),
        .o_valid      (wb_valid_out),
        .o_pc_plus_4  (wb_pc_plus_4_out),
        .o_alu_result (wb_alu_result_out),
        .o_mem_data   (wb_mem_data_out),
        .o_rd_addr    (wb_rd_addr_out),
        .o_reg_write  (wb_reg_write_out),
        .o_mem_to_reg (wb_mem_to_reg_out)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, store, delayed load,
// load+store collision, misalignment, timeout and reset during a load.
module tb_mem_access_stage;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] ma_pc_plus_4_in;
    logic [31:0] ma_alu_result_in;
    logic [31:0] ma_write_data_in;
    logic [4:0]  ma_rd_addr_in;
    logic        ma_mem_read_in;
    logic        ma_mem_write_in;
    logic        ma_reg_write_in;
    logic        ma_mem_to_reg_in;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        stall_out;
    logic        wb_valid_out;
    logic [31:0] wb_pc_plus_4_out;
    logic [31:0] wb_alu_result_out;
    logic [31:0] wb_mem_data_out;
    logic [4:0]  wb_rd_addr_out;
    logic        wb_reg_write_out;
    logic        wb_mem_to_reg_out;
    logic        misaligned_err_out;
    logic        bus_err_out;
    logic [1:0]  dbg_state_out;

    int n_cmp = 0;
    int n_mis = 0;

    logic [31:0] n_stall;
    logic [31:0] n_reqv;
    logic [31:0] req_addr;
    logic        req_we;
    logic [31:0] req_wdata;
    logic        req_stable;
    logic        bus_err_done;

    mem_access_stage #(.TIMEOUT_CYCLES(200), .CNT_W(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .ma_pc_plus_4_in    (ma_pc_plus_4_in),
        .ma_alu_result_in   (ma_alu_result_in),
        .ma_write_data_in   (ma_write_data_in),
        .ma_rd_addr_in      (ma_rd_addr_in),
        .ma_mem_read_in     (ma_mem_read_in),
        .ma_mem_write_in    (ma_mem_write_in),
        .ma_reg_write_in    (ma_reg_write_in),
        .ma_mem_to_reg_in   (ma_mem_to_reg_in),
        .dmem_req_valid     (dmem_req_valid),
        .dmem_req_ready     (dmem_req_ready),
        .dmem_req_we        (dmem_req_we),
        .dmem_req_addr      (dmem_req_addr),
        .dmem_req_wdata     (dmem_req_wdata),
        .dmem_resp_valid    (dmem_resp_valid),
        .dmem_resp_rdata    (dmem_resp_rdata),
        .stall_out          (stall_out),
        .wb_valid_out       (wb_valid_out),
        .wb_pc_plus_4_out   (wb_pc_plus_4_out),
        .wb_alu_result_out  (wb_alu_result_out),
        .wb_mem_data_out    (wb_mem_data_out),
        .wb_rd_addr_out     (wb_rd_addr_out),
        .wb_reg_write_out   (wb_reg_write_out),
        .wb_mem_to_reg_out  (wb_mem_to_reg_out),
        .misaligned_err_out (misaligned_err_out),
        .bus_err_out        (bus_err_out),
        .dbg_state_out      (dbg_state_out)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic mr, input logic mw,
                         input logic rw, input logic m2r);
        ma_pc_plus_4_in  = pc4;
        ma_alu_result_in = alu;
        ma_write_data_in = wdata;
        ma_rd_addr_in    = rd;
        ma_mem_read_in   = mr;
        ma_mem_write_in  = mw;
        ma_reg_write_in  = rw;
        ma_mem_to_reg_in = m2r;
    endtask

    task automatic drive_idle();
        drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Memory model: ready after ready_dly refused request cycles, load data
    // resp_dly cycles after acceptance. Returns once stall drops (DONE cycle).
    task automatic run_mem(input int ready_dly, input int resp_dly, input logic [31:0] rdata);
        int  cd      = 0;
        bit  pending = 0;
        bit  done    = 0;
        n_stall      = 0;
        n_reqv       = 0;
        req_addr     = 32'h0;
        req_we       = 1'b0;
        req_wdata    = 32'h0;
        req_stable   = 1'b1;
        bus_err_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            dmem_resp_valid = 1'b0;
            if (pending) begin
                cd--;
                if (cd == 0) begin
                    dmem_resp_valid = 1'b1;
                    dmem_resp_rdata = rdata;
                    pending         = 0;
                end
            end
            #1;
            if (!stall_out) begin
                done         = 1;
                bus_err_done = bus_err_out;
            end else begin
                n_stall = n_stall + 1;
                dmem_req_ready = 1'b0;
                if (dmem_req_valid) begin
                    n_reqv = n_reqv + 1;
                    if (n_reqv == 1) begin
                        req_addr  = dmem_req_addr;
                        req_we    = dmem_req_we;
                        req_wdata = dmem_req_wdata;
                    end else if (dmem_req_addr !== req_addr || dmem_req_we !== req_we ||
                                 dmem_req_wdata !== req_wdata) begin
                        req_stable = 1'b0;
                    end
                    if (n_reqv > ready_dly) begin
                        dmem_req_ready = 1'b1;
                        pending        = !dmem_req_we;
                        cd             = resp_dly;
                    end
                end
                step();
            end
        end
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        check("mem_wait_bound", 32'(done), 32'd1);
    endtask

    initial begin
        rst             = 1'b1;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
        // Aligned load presented during reset: nothing may react
        drive(32'h4, 32'h100, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall_out), 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_out), 32'd0);
        check("rst_wb_reg_write", 32'(wb_reg_write_out), 32'd0);
        check("rst_mis_err", 32'(misaligned_err_out), 32'd0);
        check("rst_bus_err", 32'(bus_err_out), 32'd0);
        check("rst_state", 32'(dbg_state_out), 32'd0);
        drive_idle();
        rst = 1'b0;

        // ALU ops, back to back, one-cycle latency
        drive(32'h1004, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("alu_stall", 32'(stall_out), 32'd0);
        step();
        drive(32'h1008, 32'h20, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        check("alu_wb_valid", 32'(wb_valid_out), 32'd1);
        check("alu_wb_alu", wb_alu_result_out, 32'h10);
        check("alu_wb_rd", 32'(wb_rd_addr_out), 32'd5);
        check("alu_wb_rw", 32'(wb_reg_write_out), 32'd1);
        check("alu_wb_pc4", wb_pc_plus_4_out, 32'h1004);
        check("alu_wb_data", wb_mem_data_out, 32'h0);
        #1;
        check("alu2_stall", 32'(stall_out), 32'd0);
        step();
        check("alu2_wb_alu", wb_alu_result_out, 32'h20);
        check("alu2_wb_rw", 32'(wb_reg_write_out), 32'd0);
        check("alu2_wb_m2r", 32'(wb_mem_to_reg_out), 32'd1);

        // Store, memory ready immediately
        drive(32'h100C, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_mem(0, 0, 32'h0);
        check("st_stall_cycles", n_stall, 32'd2);
        check("st_req_cycles", n_reqv, 32'd1);
        check("st_addr", req_addr, 32'h100);
        check("st_we", 32'(req_we), 32'd1);
        check("st_wdata", req_wdata, 32'hDEADBEEF);
        check("st_done_bubble", 32'(wb_valid_out), 32'd0);
        step();
        drive_idle();
        check("st_wb_valid", 32'(wb_valid_out), 32'd1);
        check("st_wb_rw", 32'(wb_reg_write_out), 32'd0);
        check("st_wb_pc4", wb_pc_plus_4_out, 32'h100C);
        check("st_state", 32'(dbg_state_out), 32'd0);

        // Load with two refused request cycles, data two cycles after accept
        drive(32'h1010, 32'h200, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        run_mem(2, 2, 32'hCAFEF00D);
        check("ld_stall_cycles", n_stall, 32'd6);
        check("ld_req_cycles", n_reqv, 32'd3);
        check("ld_addr", req_addr, 32'h200);
        check("ld_we", 32'(req_we), 32'd0);
        check("ld_addr_stable", 32'(req_stable), 32'd1);
        step();
        drive_idle();
        check("ld_wb_valid", 32'(wb_valid_out), 32'd1);
        check("ld_wb_data", wb_mem_data_out, 32'hCAFEF00D);
        check("ld_wb_m2r", 32'(wb_mem_to_reg_out), 32'd1);
        check("ld_wb_rw", 32'(wb_reg_write_out), 32'd1);
        check("ld_wb_rd", 32'(wb_rd_addr_out), 32'd10);
        check("ld_wb_alu", wb_alu_result_out, 32'h200);

        // Read and write both set: behaves as a minimum-latency load
        drive(32'h1014, 32'h400, 32'hAAAA5555, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        run_mem(0, 1, 32'h0BADCAFE);
        check("rw_stall_cycles", n_stall, 32'd3);
        check("rw_we", 32'(req_we), 32'd0);
        check("rw_addr", req_addr, 32'h400);
        step();
        drive_idle();
        check("rw_wb_data", wb_mem_data_out, 32'h0BADCAFE);
        check("rw_wb_rw", 32'(wb_reg_write_out), 32'd1);

        // Misaligned load
        drive(32'h1018, 32'h202, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        check("mis_stall", 32'(stall_out), 32'd0);
        check("mis_req_valid", 32'(dmem_req_valid), 32'd0);
        step();
        drive_idle();
        check("mis_pulse", 32'(misaligned_err_out), 32'd1);
        check("mis_wb_valid", 32'(wb_valid_out), 32'd1);
        check("mis_wb_rw", 32'(wb_reg_write_out), 32'd0);
        check("mis_wb_alu", wb_alu_result_out, 32'h202);
        check("mis_req_valid_after", 32'(dmem_req_valid), 32'd0);
        step();
        check("mis_pulse_end", 32'(misaligned_err_out), 32'd0);

        // Load never accepted: timeout after 200 request cycles
        drive(32'h101C, 32'h300, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
        run_mem(1000, 0, 32'h0);
        check("to_stall_cycles", n_stall, 32'd201);
        check("to_req_cycles", n_reqv, 32'd200);
        check("to_bus_err", 32'(bus_err_done), 32'd1);
        step();
        drive_idle();
        check("to_wb_valid", 32'(wb_valid_out), 32'd1);
        check("to_wb_rw", 32'(wb_reg_write_out), 32'd0);
        check("to_wb_data", wb_mem_data_out, 32'h0);
        check("to_bus_err_end", 32'(bus_err_out), 32'd0);
        check("to_state", 32'(dbg_state_out), 32'd0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h55555555;
        step();
        dmem_resp_valid = 1'b0;
        check("to_late_state", 32'(dbg_state_out), 32'd0);
        check("to_late_data", wb_mem_data_out, 32'h0);

        // Reset while waiting for load data
        drive(32'h1020, 32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("rr_in_resp", 32'(dbg_state_out), 32'd2);
        rst = 1'b1;
        #1;
        check("rr_stall", 32'(stall_out), 32'd0);
        check("rr_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rr_state", 32'(dbg_state_out), 32'd0);
        check("rr_wb_valid", 32'(wb_valid_out), 32'd0);
        step();
        drive_idle();
        rst = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h12345678;
        step();
        dmem_resp_valid = 1'b0;
        check("rr_late_state", 32'(dbg_state_out), 32'd0);
        check("rr_late_data", wb_mem_data_out, 32'h0);
        drive(32'h1024, 32'h44, 32'h0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        drive_idle();
        check("rr_alu_valid", 32'(wb_valid_out), 32'd1);
        check("rr_alu_result", wb_alu_result_out, 32'h44);
        check("rr_alu_rw", 32'(wb_reg_write_out), 32'd1);
        check("rr_alu_rd", 32'(wb_rd_addr_out), 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
